page_tbl_ctrl: RTL and testbench
================================

PAGE_TBL_CTRL -- requirements
Module: page_tbl_ctrl

Interface
REQ-001 Param ADDR_BITS, default 5, page table address width (32 entries).
REQ-002 Param DATA_BITS, default 16, page table entry width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 clr  in  1  single-cycle pulse; re-zeroes the whole table.
REQ-006 cfg_valid / cfg_ready  in / out  1 / 1  config write handshake.
REQ-007 cfg_addr / cfg_data  in  ADDR_BITS / DATA_BITS  config write address and data.
REQ-008 req0_valid / req0_ready / req0_addr  in / out / in  1 / 1 / ADDR_BITS  lookup requester 0.
REQ-009 req1_valid / req1_ready / req1_addr  in / out / in  1 / 1 / ADDR_BITS  lookup requester 1.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  lookup response handshake.
REQ-011 rsp_id / rsp_data  out  1 / DATA_BITS  response requester index and entry value.
REQ-012 init_done  out  1  high while in RUN.

Function
REQ-013 FSM states are INIT and RUN; rst or clr forces INIT with sweep counter 0.
REQ-014 INIT writes 0 to entry counter each cycle on RAM port A; after entry 31 the next state is RUN (32 cycles).
REQ-015 In INIT, cfg_ready, req0_ready and req1_ready are 0.
REQ-016 clr during INIT restarts the sweep at entry 0.
REQ-017 In RUN, cfg_ready is 1 and an accepted config write drives port A in the same cycle.
REQ-018 Lookup arbitration is round-robin over valid requesters; the pointer moves to the other requester after each grant; after reset the pointer favours requester 0.
REQ-019 reqN_ready is 1 only for the granted requester.
REQ-020 A grant requires RUN and (fifo_count + inflight - pop_this_cycle) < 2.
REQ-021 ready may depend combinationally on valid; valid and address are held until accepted.
REQ-022 Port B is enabled on grant; the entry is captured into a 2-entry response FIFO one cycle later with the requester id.
REQ-023 Latency from acceptance in cycle t to rsp_valid is cycle t+2; sustained throughput is 1 lookup/cycle while rsp_ready=1.
REQ-024 Responses return in grant order; rsp_id/rsp_data are stable while rsp_valid=1 and rsp_ready=0.
REQ-025 Same-cycle config write and lookup to the same address: the response returns the new cfg_data (bypass).
REQ-026 A lookup accepted the cycle after a config write to its address returns the written data.
REQ-027 On clr, lookups already in flight or in the FIFO are still delivered, with pre-clear data.

Reset
REQ-028 After rst: state INIT, sweep counter 0, RR pointer on requester 0, FIFO empty, inflight 0.
REQ-029 After rst: rsp_valid, rsp_id, rsp_data, cfg_ready, req0_ready, req1_ready and init_done are all 0.

Structure
REQ-030 ADDR_BITS/DATA_BITS defaults, FSM state encoding and FIFO depth (2) go in a shared package.
REQ-031 Table storage is one page_tbl_16w_32d instance, with clka = clkb = clk.
REQ-032 The response FIFO is inline logic, not a separate module.

Verification
REQ-033 rst, then idle: init_done rises exactly 32 cycles after rst deasserts; every address reads 0x0000.
REQ-034 Write addr 5 = 0xBEEF, then req0 reads addr 5 the next cycle -> rsp_data 0xBEEF, rsp_id 0, two cycles after acceptance.
REQ-035 req0 and req1 both valid for 4 cycles, rsp_ready=1 -> grants alternate 0,1,0,1; responses arrive in order with 1/cycle throughput.
REQ-036 rsp_ready=0 with continuous requests -> exactly 2 lookups accepted, then ready stays 0 and data is held; releasing rsp_ready drains in order.
REQ-037 Same-cycle write addr 9 = 0x1234 and read addr 9 -> response 0x1234.
REQ-038 Write addr 3 = 0xAAAA, issue read addr 3, pulse clr the same cycle -> response 0xAAAA; after the re-init, addr 3 reads 0x0000.

Source files
------------

// File: rtl/page_tbl_ctrl_pkg.sv
// Shared parameters, FSM encoding and response FIFO sizing for the page table
// controller and its storage.
package page_tbl_ctrl_pkg;

    localparam int DEF_ADDR_BITS = 5;
    localparam int DEF_DATA_BITS = 16;

    localparam int FIFO_DEPTH    = 2;
    localparam int FIFO_PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_BITS = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/page_tbl_16w_32d.sv
// Simple dual-port page table RAM: port A writes, port B reads with one cycle
// of registered read latency.
module page_tbl_16w_32d
    import page_tbl_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clka,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [ADDR_BITS-1:0] addra,
    input  logic [DATA_BITS-1:0] dina,
    input  logic                 clkb,
    input  logic                 enb,
    input  logic [ADDR_BITS-1:0] addrb,
    output logic [DATA_BITS-1:0] doutb
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // Read-before-write on a same-address collision; the controller bypasses.
    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/page_tbl_ctrl.sv
// Page table controller: zeroing sweep after reset/clear, config writes, and
// two round-robin lookup requesters sharing a 2-entry in-order response FIFO.
module page_tbl_ctrl
    import page_tbl_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ADDR_BITS-1:0] cfg_addr,
    input  logic [DATA_BITS-1:0] cfg_data,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_BITS-1:0] req1_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 init_done
);

    localparam int OCC_BITS = FIFO_CNT_BITS + 1;

    state_t                 state;
    logic [ADDR_BITS-1:0]   sweep_cnt;
    logic                   rr_ptr;
    logic                   inflight;
    logic                   inflight_id;
    logic                   bp_hit;
    logic [DATA_BITS-1:0]   bp_data;
    logic [DATA_BITS-1:0]   fifo_data [FIFO_DEPTH];
    logic                   fifo_id   [FIFO_DEPTH];
    logic [FIFO_PTR_BITS-1:0] fifo_wr_ptr;
    logic [FIFO_PTR_BITS-1:0] fifo_rd_ptr;
    logic [FIFO_CNT_BITS-1:0] fifo_count;

    logic                   run;
    logic                   cfg_fire;
    logic                   pop;
    logic                   push;
    logic [OCC_BITS-1:0]    occupancy;
    logic                   can_grant;
    logic                   grant;
    logic                   grant_id;
    logic [ADDR_BITS-1:0]   grant_addr;
    logic                   ram_ena;
    logic [ADDR_BITS-1:0]   ram_addra;
    logic [DATA_BITS-1:0]   ram_dina;
    logic [DATA_BITS-1:0]   ram_doutb;
    logic [DATA_BITS-1:0]   capture_data;

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign cfg_ready = run;
    assign cfg_fire  = run && cfg_valid;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight;

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + OCC_BITS'(inflight) - OCC_BITS'(pop);
    assign can_grant = run && (occupancy < OCC_BITS'(FIFO_DEPTH));

    always_comb begin
        grant    = 1'b0;
        grant_id = 1'b0;
        if (can_grant) begin
            if (req0_valid && req1_valid) begin
                grant    = 1'b1;
                grant_id = rr_ptr;
            end else if (req0_valid) begin
                grant    = 1'b1;
                grant_id = 1'b0;
            end else if (req1_valid) begin
                grant    = 1'b1;
                grant_id = 1'b1;
            end
        end
    end

    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant && grant_id;
    assign grant_addr = grant_id ? req1_addr : req0_addr;

    assign ram_ena   = !run || cfg_fire;
    assign ram_addra = run ? cfg_addr : sweep_cnt;
    assign ram_dina  = run ? cfg_data : '0;

    page_tbl_16w_32d #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_tbl (
        .clka  (clk),
        .ena   (ram_ena),
        .wea   (ram_ena),
        .addra (ram_addra),
        .dina  (ram_dina),
        .clkb  (clk),
        .enb   (grant),
        .addrb (grant_addr),
        .doutb (ram_doutb)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + ADDR_BITS'(1);
            if (&sweep_cnt) begin
                state <= ST_RUN;
            end
        end
    end

    // A write landing in the same cycle as the read is forwarded at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            inflight    <= 1'b0;
            inflight_id <= 1'b0;
            bp_hit      <= 1'b0;
            bp_data     <= '0;
        end else begin
            inflight    <= grant;
            inflight_id <= grant_id;
            bp_hit      <= grant && cfg_fire && (cfg_addr == grant_addr);
            bp_data     <= cfg_data;
            if (grant) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

    assign capture_data = bp_hit ? bp_data : ram_doutb;

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[fifo_wr_ptr] <= capture_data;
                fifo_id[fifo_wr_ptr]   <= inflight_id;
                fifo_wr_ptr            <= FIFO_PTR_BITS'(fifo_wr_ptr + 1'b1);
            end
            if (pop) begin
                fifo_rd_ptr <= FIFO_PTR_BITS'(fifo_rd_ptr + 1'b1);
            end
            fifo_count <= fifo_count + FIFO_CNT_BITS'(push) - FIFO_CNT_BITS'(pop);
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign rsp_id    = fifo_id[fifo_rd_ptr];
    assign rsp_data  = fifo_data[fifo_rd_ptr];

endmodule

// File: tb/tb_page_tbl_ctrl.sv
// Self-checking bench for page_tbl_ctrl: directed scenarios plus random
// traffic, all compared each cycle against a transaction-level table model.
module tb_page_tbl_ctrl;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          init_done;

    always #5 clk = ~clk;

    page_tbl_ctrl #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .init_done  (init_done)
    );

    // Model: table contents, accepted lookups awaiting delivery, INIT countdown.
    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_tbl [N];
    int            init_left;
    int            cyc;
    logic          favour;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs already driven; check, advance model, clear pulses.
    task automatic step();
        logic          run;
        logic          exp_valid;
        logic          pop;
        logic          cfg_fire;
        logic          g0;
        logic          g1;
        logic [AW-1:0] addr;
        rsp_t          ent;
        #3;
        run       = (init_left == 0);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        pop       = exp_valid && rsp_ready;
        cfg_fire  = run && cfg_valid;
        g0 = 1'b0;
        g1 = 1'b0;
        if (run && (exp_q.size() - (pop ? 1 : 0)) < 2) begin
            if (req0_valid && req1_valid) begin
                g0 = (favour == 1'b0);
                g1 = (favour == 1'b1);
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        check("init_done", init_done, run);
        check("cfg_ready", cfg_ready, run);
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            check("rsp_id", rsp_id, exp_q[0].id);
            check("rsp_data", rsp_data, exp_q[0].data);
        end
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (g0 || g1) begin
            addr     = g1 ? req1_addr : req0_addr;
            ent.id   = g1;
            ent.data = (cfg_fire && cfg_addr == addr) ? cfg_data : ref_tbl[addr];
            ent.due  = cyc + 2;
            exp_q.push_back(ent);
            favour = ~g1;
        end
        if (cfg_fire) begin
            ref_tbl[cfg_addr] = cfg_data;
        end
        if (clr) begin
            for (int i = 0; i < N; i++) ref_tbl[i] = '0;
            init_left = 32;
        end else if (init_left > 0) begin
            init_left--;
        end
        cyc++;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        cfg_valid = 1'b0;
        if (g0) req0_valid = 1'b0;
        if (g1) req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        favour = 1'b0;
        for (int i = 0; i < N; i++) ref_tbl[i] = '0;
        rst = 1'b1;
        clr = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        req0_valid = 1'b0;
        req0_addr = '0;
        req1_valid = 1'b0;
        req1_addr = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_init_done", init_done, 0);
        rst = 1'b0;
        init_left = 32;

        // Sweep takes 32 cycles, then every entry reads zero.
        idle(32);
        for (int a = 0; a < N; a++) begin
            req0_valid = 1'b1;
            req0_addr  = AW'(a);
            step();
        end
        idle(4);

        // Write then read the next cycle.
        cfg_valid = 1'b1; cfg_addr = 5'd5; cfg_data = 16'hBEEF;
        step();
        req0_valid = 1'b1; req0_addr = 5'd5;
        step();
        step();
        check("beef_valid", rsp_valid, 1);
        check("beef_id", rsp_id, 0);
        check("beef_data", rsp_data, 16'hBEEF);
        idle(3);

        // Both requesters contending with a free-running response port.
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_addr = AW'(10 + i); cfg_data = DW'(16'h1000 + i);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd10;
            req1_valid = 1'b1; req1_addr = 5'd11;
            step();
        end
        idle(6);

        // Response port stalled: only two lookups may be outstanding.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd12;
            req1_valid = 1'b1; req1_addr = 5'd13;
            step();
        end
        rsp_ready = 1'b1;
        idle(8);

        // Same-cycle write and read of one address.
        cfg_valid = 1'b1; cfg_addr = 5'd9; cfg_data = 16'h1234;
        req1_valid = 1'b1; req1_addr = 5'd9;
        step();
        step();
        check("bypass_valid", rsp_valid, 1);
        check("bypass_id", rsp_id, 1);
        check("bypass_data", rsp_data, 16'h1234);
        idle(3);

        // Clear with a lookup in flight keeps the old data for that lookup.
        cfg_valid = 1'b1; cfg_addr = 5'd3; cfg_data = 16'hAAAA;
        step();
        req0_valid = 1'b1; req0_addr = 5'd3; clr = 1'b1;
        step();
        step();
        check("clr_inflight_valid", rsp_valid, 1);
        check("clr_inflight_data", rsp_data, 16'hAAAA);
        idle(34);
        req0_valid = 1'b1; req0_addr = 5'd3;
        step();
        step();
        check("after_clr_valid", rsp_valid, 1);
        check("after_clr_data", rsp_data, 0);
        idle(3);

        // Random traffic, requests held until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid && $urandom_range(99) < 50) begin
                req0_valid = 1'b1;
                req0_addr  = AW'($urandom_range(N - 1));
            end
            if (!req1_valid && $urandom_range(99) < 50) begin
                req1_valid = 1'b1;
                req1_addr  = AW'($urandom_range(N - 1));
            end
            if (init_left == 0 && $urandom_range(99) < 30) begin
                cfg_valid = 1'b1;
                cfg_addr  = AW'($urandom_range(N - 1));
                cfg_data  = DW'($urandom);
            end
            clr       = ($urandom_range(299) == 0);
            rsp_ready = ($urandom_range(99) < 70);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
